i2c_master_fsm: RTL and testbench

I2C_MASTER_FSM -- requirements
Module: i2c_master_fsm

---
 rtl/i2c_master_fsm.sv | 194 +++++++++++++++++++
 tb/tb_i2c_master_fsm.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_fsm.sv
// Single-byte I2C master sequencer. It drives SDA (open drain) and tells an
// external SCL generator when to start and when to park SCL high. Each
// transaction is START, address + R/W, ACK, one data byte, ACK/NACK, STOP.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start; SDA released, SCL parked high
// START   | SDA held low with SCL high for SETUP_CYC cycles
// EN      | one-cycle i_clock_en pulse to launch the SCL generator
// ADDR    | shifting out {addr,rw}, sampling the slave ACK on bit 9
// DATA    | shifting wdata out (write) or sda_in in (read), bit 9 ACK/NACK
// STOP    | i_clock_stop pulse, then SDA low with SCL high for STOP_CYC
// DONE    | one-cycle done pulse, back to IDLE
module i2c_master_fsm #(
  parameter int SETUP_CYC = 8,
  parameter int STOP_CYC  = 8
) (
  input  logic       pclk,
  input  logic       prst_n,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  input  logic       i_clk,
  input  logic       sda_in,
  output logic       i_clock_en,
  output logic       i_clock_stop,
  output logic       sda_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rdata
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_EN,
    ST_ADDR,
    ST_DATA,
    ST_STOP,
    ST_DONE
  } state_t;

  localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC);
  localparam logic [7:0] STOP_LD  = 8'(STOP_CYC);

  state_t     state;
  logic       i_clk_q;
  logic       scl_rise;
  logic       scl_fall;
  logic [7:0] shift_q;
  logic [7:0] wdata_q;
  logic       rw_q;
  logic [3:0] bit_cnt;
  logic [7:0] hold_cnt;

  assign scl_rise = ~i_clk_q & i_clk;
  assign scl_fall = i_clk_q & ~i_clk;

  // Delayed copy of SCL for the one-cycle rise/fall strobes; SCL idles high.
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      i_clk_q <= 1'b1;
    end else begin
      i_clk_q <= i_clk;
    end
  end

  // Transaction sequencer with all outputs registered.
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      state        <= ST_IDLE;
      i_clock_en   <= 1'b0;
      i_clock_stop <= 1'b0;
      sda_oe       <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      ack_err      <= 1'b0;
      rdata        <= 8'h00;
      shift_q      <= 8'h00;
      wdata_q      <= 8'h00;
      rw_q         <= 1'b0;
      bit_cnt      <= 4'd0;
      hold_cnt     <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            shift_q  <= {addr, rw};
            wdata_q  <= wdata;
            rw_q     <= rw;
            ack_err  <= 1'b0;
            busy     <= 1'b1;
            sda_oe   <= 1'b1;
            bit_cnt  <= 4'd0;
            hold_cnt <= SETUP_LD;
            state    <= ST_START;
          end
        end

        // Down-count the START hold; terminal count at 1 gives SETUP_CYC cycles.
        ST_START: begin
          if (hold_cnt <= 8'd1) begin
            hold_cnt   <= 8'd0;
            i_clock_en <= 1'b1;
            state      <= ST_EN;
          end else begin
            hold_cnt <= hold_cnt - 8'd1;
          end
        end

        ST_EN: begin
          i_clock_en <= 1'b0;
          state      <= ST_ADDR;
        end

        ST_ADDR: begin
          if (scl_rise) begin
            if (bit_cnt == 4'd8 && sda_in) ack_err <= 1'b1;
            if (bit_cnt != 4'd9) bit_cnt <= bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt <= 4'd7) begin
              sda_oe  <= ~shift_q[7];
              shift_q <= {shift_q[6:0], 1'b0};
            end else if (bit_cnt == 4'd8) begin
              sda_oe <= 1'b0;
            end else if (ack_err) begin
              sda_oe       <= 1'b1;
              i_clock_stop <= 1'b1;
              hold_cnt     <= STOP_LD;
              state        <= ST_STOP;
            end else begin
              // This fall already belongs to data bit 1.
              bit_cnt <= 4'd0;
              state   <= ST_DATA;
              if (rw_q) begin
                sda_oe <= 1'b0;
              end else begin
                sda_oe  <= ~wdata_q[7];
                shift_q <= {wdata_q[6:0], 1'b0};
              end
            end
          end
        end

        ST_DATA: begin
          if (scl_rise) begin
            if (bit_cnt <= 4'd7 && rw_q) rdata <= {rdata[6:0], sda_in};
            if (bit_cnt == 4'd8 && !rw_q && sda_in) ack_err <= 1'b1;
            if (bit_cnt != 4'd9) bit_cnt <= bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt <= 4'd7) begin
              sda_oe  <= rw_q ? 1'b0 : ~shift_q[7];
              shift_q <= {shift_q[6:0], 1'b0};
            end else if (bit_cnt == 4'd8) begin
              // ACK slot on write, NACK from the master on a single-byte read.
              sda_oe <= 1'b0;
            end else begin
              sda_oe       <= 1'b1;
              i_clock_stop <= 1'b1;
              hold_cnt     <= STOP_LD;
              state        <= ST_STOP;
            end
          end
        end

        // SCL parks high after the stop pulse; SDA is released at terminal count.
        ST_STOP: begin
          if (i_clock_stop) begin
            i_clock_stop <= 1'b0;
          end else if (hold_cnt <= 8'd1) begin
            hold_cnt <= 8'd0;
            sda_oe   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= ST_DONE;
          end else begin
            hold_cnt <= hold_cnt - 8'd1;
          end
        end

        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_fsm.sv
// Bench for i2c_master_fsm: SCL generator and I2C slave model, a scoreboard of
// expected transaction outcomes, and a negedge monitor that checks each done.
module tb_i2c_master_fsm;

  logic       pclk = 1'b0;
  logic       prst_n = 1'b1;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] addr = 7'h00;
  logic [7:0] wdata = 8'h00;
  logic       i_clk = 1'b1;
  logic       sda_in;
  logic       i_clock_en, i_clock_stop, sda_oe, busy, done, ack_err;
  logic [7:0] rdata;

  logic       slave_pull = 1'b0;
  assign sda_in = ~(sda_oe | slave_pull);

  i2c_master_fsm #(.SETUP_CYC(8), .STOP_CYC(8)) dut (
    .pclk(pclk), .prst_n(prst_n), .start(start), .rw(rw), .addr(addr),
    .wdata(wdata), .i_clk(i_clk), .sda_in(sda_in), .i_clock_en(i_clock_en),
    .i_clock_stop(i_clock_stop), .sda_oe(sda_oe), .busy(busy), .done(done),
    .ack_err(ack_err), .rdata(rdata)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    int          rises;
    logic [17:0] bits;
    logic        ack_err;
    logic [7:0]  rdata;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // slave / generator configuration
  logic       s_rw = 1'b0, s_ack_addr = 1'b1, s_ack_data = 1'b1;
  logic [7:0] s_rbyte = 8'h00;
  int         half = 3;

  // generator / monitor state
  bit          running = 1'b0;
  int          ph = 0, rise_cnt = 0, ev = 0, en_w = 0, stop_w = 0, done_seen = 0;
  logic [17:0] rec_bits = '0;
  logic        en_prev = 1'b0, stop_prev = 1'b0, done_prev = 1'b0, overlap = 1'b0;
  logic        prev_scl = 1'b1, prev_sda = 1'b1, sda_now;
  logic [7:0]  model_rdata = 8'h00;

  function automatic void chk(input string nm, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, expv, expv, $time);
    end
  endfunction

  // Slave behaviour for the upcoming bit number b (1-based, 9 and 18 are ACK slots).
  function automatic logic slave_f(input int b);
    if (!s_ack_addr) return 1'b0;
    if (b == 9) return 1'b1;
    if (s_rw && b >= 10 && b <= 17) return ~s_rbyte[3'(17 - b)];
    if (!s_rw && b == 18) return s_ack_data;
    return 1'b0;
  endfunction

  // SCL generator, slave, bus-condition tracker and done monitor.
  always @(negedge pclk) begin
    if (!prst_n) begin
      running = 1'b0; i_clk = 1'b1; slave_pull = 1'b0; rise_cnt = 0; rec_bits = '0;
      ev = 0; en_prev = 1'b0; stop_prev = 1'b0; en_w = 0; stop_w = 0;
      done_prev = 1'b0; overlap = 1'b0; prev_scl = 1'b1; prev_sda = 1'b1;
    end else begin
      if (i_clock_en && i_clock_stop) overlap = 1'b1;
      if (i_clock_en) en_w++;
      else if (en_prev) begin
        chk("clock_en_width", en_w, 1);
        en_w = 0; running = 1'b1; ph = 0; rise_cnt = 0;
      end
      if (i_clock_stop) stop_w++;
      else if (stop_prev) begin
        chk("clock_stop_width", stop_w, 1);
        stop_w = 0; running = 1'b0; i_clk = 1'b1;
      end
      en_prev = i_clock_en;
      stop_prev = i_clock_stop;
      if (running) begin
        ph++;
        if (ph >= half) begin
          ph = 0;
          i_clk = ~i_clk;
          if (i_clk) begin
            rise_cnt++;
            rec_bits = {rec_bits[16:0], ~sda_oe};
          end
        end
      end
      if (!running) slave_pull = 1'b0;
      else if (!i_clk) slave_pull = slave_f(rise_cnt + 1);
      sda_now = ~(sda_oe | slave_pull);
      // 1 = START (SDA falls, SCL high), 2 = STOP (SDA rises, SCL high)
      if (prev_scl && i_clk && (prev_sda != sda_now)) ev = ev * 3 + (sda_now ? 2 : 1);
      prev_scl = i_clk;
      prev_sda = sda_now;
      if (done) begin
        chk("done_width", int'(done_prev), 0);
        chk("pending_txn", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          chk("scl_rises", rise_cnt, e.rises);
          chk("master_sda_bits", int'(rec_bits), int'(e.bits));
          chk("ack_err", int'(ack_err), int'(e.ack_err));
          chk("rdata", int'(rdata), int'(e.rdata));
          chk("busy_at_done", int'(busy), 0);
          chk("start_stop_order", ev, 5);
          chk("en_stop_overlap", int'(overlap), 0);
        end
        rec_bits = '0; ev = 0; overlap = 1'b0; rise_cnt = 0;
        done_seen++;
      end
      done_prev = done;
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_clock_en"}, int'(i_clock_en), 0);
    chk({tag, "_clock_stop"}, int'(i_clock_stop), 0);
    chk({tag, "_sda_oe"}, int'(sda_oe), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_ack_err"}, int'(ack_err), 0);
    chk({tag, "_rdata"}, int'(rdata), 0);
  endtask

  task automatic do_txn(input logic t_rw, input logic [6:0] t_addr, input logic [7:0] t_wdata,
                        input logic t_aa, input logic t_ad, input logic [7:0] t_rb,
                        input bit poke, input bit abort);
    exp_t e;
    int   n0, k;
    k = 0;
    while (busy && k < 5000) begin @(negedge pclk); k++; end
    s_rw = t_rw; s_ack_addr = t_aa; s_ack_data = t_ad; s_rbyte = t_rb;
    // reference: bit string the master must put on SDA, outcome flags
    e.rises = t_aa ? 18 : 9;
    e.bits = '0;
    for (int i = 6; i >= 0; i--) e.bits = {e.bits[16:0], t_addr[i]};
    e.bits = {e.bits[16:0], t_rw};
    e.bits = {e.bits[16:0], 1'b1};
    if (t_aa) begin
      for (int i = 7; i >= 0; i--) e.bits = {e.bits[16:0], t_rw ? 1'b1 : t_wdata[i]};
      e.bits = {e.bits[16:0], 1'b1};
    end
    e.ack_err = !t_aa || (!t_rw && !t_ad);
    if (t_rw && t_aa) model_rdata = t_rb;
    e.rdata = model_rdata;
    exp_q.push_back(e);
    @(negedge pclk);
    rw = t_rw; addr = t_addr; wdata = t_wdata; start = 1'b1;
    n0 = done_seen;
    @(negedge pclk);
    start = 1'b0;
    chk("busy_on_accept", int'(busy), 1);
    addr = 7'($urandom); wdata = 8'($urandom); rw = 1'($urandom);
    if (poke || abort) begin
      k = 0;
      while (!(rise_cnt >= 12 && !i_clk) && k < 5000) begin @(negedge pclk); k++; end
      chk("reached_data_bit4", int'(rise_cnt >= 12), 1);
      if (poke) begin
        start = 1'b1; rw = ~t_rw; addr = ~t_addr; wdata = ~t_wdata;
        @(negedge pclk);
        start = 1'b0;
      end else begin
        #2 prst_n = 1'b0;
        #1 check_reset_outputs("abort_reset");
        exp_q.delete();
        model_rdata = 8'h00;
        repeat (2) @(negedge pclk);
        #2 prst_n = 1'b1;
        return;
      end
    end
    k = 0;
    while (done_seen == n0 && k < 5000) begin @(negedge pclk); k++; end
    repeat (3) @(negedge pclk);
    chk("ack_err_hold", int'(ack_err), int'(e.ack_err));
    chk("rdata_hold", int'(rdata), int'(e.rdata));
    if (poke) repeat (300) @(negedge pclk);
    chk("done_count", done_seen - n0, 1);
  endtask

  initial begin
    #1 prst_n = 1'b0;
    repeat (3) @(negedge pclk);
    #1 check_reset_outputs("por");
    #1 prst_n = 1'b1;
    half = 3;
    do_txn(1'b0, 7'h50, 8'hA5, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
    do_txn(1'b1, 7'h50, 8'h00, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0);
    do_txn(1'b0, 7'h12, 8'h77, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    do_txn(1'b0, 7'h33, 8'hC3, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0);
    do_txn(1'b0, 7'h50, 8'h11, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1);
    do_txn(1'b0, 7'h50, 8'h5A, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
    do_txn(1'b0, 7'h2B, 8'h0F, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int n = 0; n < 24; n++) begin
      half = $urandom_range(2, 5);
      do_txn(1'($urandom), 7'($urandom), 8'($urandom), ($urandom_range(0, 4) != 0),
             1'($urandom), 8'($urandom), 1'b0, 1'b0);
    end
    repeat (20) @(negedge pclk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, vectors %0d, miscompares %0d", vectors, miscompares);
    $fatal(1);
  end

endmodule
